// File: rtl/bus_arbiter_if.sv
// Bus bundle for bus_arbiter: the IFU read port, the LSU read/write port
// and the shared memory port, grouped as one interface.
//   master modport : the arbiter itself (takes IFU/LSU requests and the
//                    memory responses, drives IFU/LSU responses and the
//                    memory request)
//   slave modport  : the attached agents (IFU, LSU and memory)
// Parameters: ADDR_W address width, DATA_W data width (byte strobes are
// DATA_W/8 bits wide).
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // IFU port (read-only)
    logic [ADDR_W-1:0]   ifu_araddr;
    logic                ifu_arvalid;
    logic [DATA_W-1:0]   ifu_rdata;
    logic                ifu_rvalid;
    logic                ifu_rerr;
    // LSU port (read or write)
    logic [ADDR_W-1:0]   lsu_araddr;
    logic                lsu_arvalid;
    logic [DATA_W-1:0]   lsu_rdata;
    logic                lsu_rvalid;
    logic [ADDR_W-1:0]   lsu_awaddr;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wstrb;
    logic                lsu_awvalid;
    logic                lsu_bvalid;
    logic                lsu_err;
    // Memory port
    logic [ADDR_W-1:0]   mem_araddr;
    logic                mem_arvalid;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_rvalid;
    logic [ADDR_W-1:0]   mem_awaddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_awvalid;
    logic                mem_bvalid;

    modport master (
        input  ifu_araddr, ifu_arvalid,
        output ifu_rdata, ifu_rvalid, ifu_rerr,
        input  lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_wdata, lsu_wstrb, lsu_awvalid,
        output lsu_rdata, lsu_rvalid, lsu_bvalid, lsu_err,
        output mem_araddr, mem_arvalid, mem_awaddr, mem_wdata, mem_wstrb, mem_awvalid,
        input  mem_rdata, mem_rvalid, mem_bvalid
    );

    modport slave (
        output ifu_araddr, ifu_arvalid,
        input  ifu_rdata, ifu_rvalid, ifu_rerr,
        output lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_wdata, lsu_wstrb, lsu_awvalid,
        input  lsu_rdata, lsu_rvalid, lsu_bvalid, lsu_err,
        input  mem_araddr, mem_arvalid, mem_awaddr, mem_wdata, mem_wstrb, mem_awvalid,
        output mem_rdata, mem_rvalid, mem_bvalid
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master / one-slave arbiter sharing the memory bus between the IFU
// (reads) and the LSU (reads and writes). One transaction at a time,
// round-robin on conflicts, responses routed only to the owner, and a hung
// slave converted into an error response after TIMEOUT+1 owned cycles
// (TIMEOUT = 0 waits forever).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; also forces every output to 0
//   bus  bus_arbiter_if.master (IFU port, LSU port, memory port)
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    bus_arbiter_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, IFU_RD, LSU_RD, LSU_WR, DONE} state_t;

    state_t              state, state_nxt;
    logic                last_owner, last_owner_nxt; // 0 = IFU, 1 = LSU
    logic [CNT_W-1:0]    wait_cnt;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [STRB_W-1:0]   req_wstrb;

    logic                grant;
    logic [ADDR_W-1:0]   grant_addr;
    logic [DATA_W-1:0]   grant_wdata;
    logic [STRB_W-1:0]   grant_wstrb;
    logic                lsu_req;
    logic                rd_owned, owned, resp_in, timed_out, active;

    assign lsu_req   = bus.lsu_arvalid || bus.lsu_awvalid;
    assign rd_owned  = (state == IFU_RD) || (state == LSU_RD);
    assign owned     = rd_owned || (state == LSU_WR);
    assign resp_in   = rd_owned ? bus.mem_rvalid : ((state == LSU_WR) && bus.mem_bvalid);
    // A real response in the timeout cycle wins over the error.
    assign timed_out = owned && !resp_in && (TIMEOUT != 0) && (wait_cnt == TMO);
    // Reset must suppress an in-flight response in the same cycle, so all
    // outputs are qualified by it.
    assign active    = !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b0;
            wait_cnt   <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wstrb  <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            if (grant) begin
                wait_cnt  <= '0;
                req_addr  <= grant_addr;
                req_wdata <= grant_wdata;
                req_wstrb <= grant_wstrb;
            end else if (owned && !resp_in && wait_cnt != TMO) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        grant          = 1'b0;
        grant_addr     = '0;
        grant_wdata    = '0;
        grant_wstrb    = '0;
        unique case (state)
            IDLE: begin
                // IFU wins only when alone or when the LSU owned last time.
                if (bus.ifu_arvalid && (!lsu_req || last_owner)) begin
                    state_nxt      = IFU_RD;
                    last_owner_nxt = 1'b0;
                    grant          = 1'b1;
                    grant_addr     = bus.ifu_araddr;
                end else if (bus.lsu_awvalid) begin
                    state_nxt      = LSU_WR;
                    last_owner_nxt = 1'b1;
                    grant          = 1'b1;
                    grant_addr     = bus.lsu_awaddr;
                    grant_wdata    = bus.lsu_wdata;
                    grant_wstrb    = bus.lsu_wstrb;
                end else if (bus.lsu_arvalid) begin
                    state_nxt      = LSU_RD;
                    last_owner_nxt = 1'b1;
                    grant          = 1'b1;
                    grant_addr     = bus.lsu_araddr;
                end
            end
            IFU_RD, LSU_RD, LSU_WR: begin
                if (resp_in || timed_out) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ifu_rvalid  = active && (state == IFU_RD) && (resp_in || timed_out);
        bus.ifu_rerr    = active && (state == IFU_RD) && timed_out;
        bus.ifu_rdata   = (active && (state == IFU_RD) && resp_in) ? bus.mem_rdata : '0;
        bus.lsu_rvalid  = active && (state == LSU_RD) && (resp_in || timed_out);
        bus.lsu_bvalid  = active && (state == LSU_WR) && (resp_in || timed_out);
        bus.lsu_err     = active && (state == LSU_RD || state == LSU_WR) && timed_out;
        bus.lsu_rdata   = (active && (state == LSU_RD) && resp_in) ? bus.mem_rdata : '0;
        bus.mem_arvalid = active && rd_owned && !timed_out;
        bus.mem_araddr  = (active && rd_owned) ? req_addr : '0;
        bus.mem_awvalid = active && (state == LSU_WR) && !timed_out;
        bus.mem_awaddr  = (active && state == LSU_WR) ? req_addr  : '0;
        bus.mem_wdata   = (active && state == LSU_WR) ? req_wdata : '0;
        bus.mem_wstrb   = (active && state == LSU_WR) ? req_wstrb : '0;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Two-master, one-slave arbiter that shares the core's single memory bus between the instruction fetch unit (read-only) and the load/store unit (read and write).
- Sits between the IFU/LSU bus ports and the memory/crossbar port.
- Serialises transactions, routes responses only to the current owner, and converts a hung slave into an error response after a bounded timeout.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles an owned transaction may wait for a response; 0 disables timeout

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- ifu_araddr  in  ADDR_W  IFU read address
- ifu_arvalid  in  1  IFU read request; held high until ifu_rvalid
- ifu_rdata  out  DATA_W  read data to IFU
- ifu_rvalid  out  1  IFU response strobe, one cycle
- ifu_rerr  out  1  IFU response is a timeout error; valid with ifu_rvalid
- lsu_araddr  in  ADDR_W  LSU read address
- lsu_arvalid  in  1  LSU read request; held until lsu_rvalid
- lsu_rdata  out  DATA_W  read data to LSU
- lsu_rvalid  out  1  LSU read response strobe
- lsu_awaddr  in  ADDR_W  LSU write address
- lsu_wdata  in  DATA_W  LSU write data
- lsu_wstrb  in  DATA_W/8  byte strobes
- lsu_awvalid  in  1  LSU write request; held until lsu_bvalid
- lsu_bvalid  out  1  LSU write response strobe
- lsu_err  out  1  LSU response is a timeout error; valid with lsu_rvalid or lsu_bvalid
- mem_araddr, mem_arvalid  out  ADDR_W, 1  slave read request
- mem_rdata  in  DATA_W  slave read data
- mem_rvalid  in  1  slave read response strobe
- mem_awaddr, mem_wdata, mem_wstrb, mem_awvalid  out  –  slave write request
- mem_bvalid  in  1  slave write response strobe

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR, DONE.
- Each LSU request is a read or a write, never both. lsu_arvalid and lsu_awvalid together is illegal; in that case the write wins.
- IDLE, no request: stay in IDLE.
- IDLE, one requester active: grant it.
  - ifu_arvalid → IFU_RD
  - lsu_arvalid → LSU_RD
  - lsu_awvalid → LSU_WR
- IDLE, IFU and LSU both active: round-robin.
  - Grant the master that did not own the previous transaction.
  - 1-bit last_owner register; reset value 0 = IFU, so the LSU wins the first conflict.
- On grant, latch address, write data and strobes into request registers. The master's inputs are not used again during the transaction.
- last_owner updates on grant.
- Owned states drive the latched request to the slave:
  - mem_arvalid = 1 in IFU_RD and LSU_RD
  - mem_awvalid = 1 in LSU_WR
- mem_*valid stay high until the response or timeout. All other mem outputs are 0 when not owned.
- Response routing:
  - mem_rvalid/mem_bvalid is forwarded combinationally to the owner only, same cycle, with mem_rdata passed through.
  - The non-owner's valids stay 0.
  - Next state is DONE.
- Timeout:
  - A wait counter clears on grant and increments each owned cycle without a response.
  - When it reaches TIMEOUT, the owner gets rvalid/bvalid plus err=1 with rdata=0, and mem_*valid drops. Next state is DONE.
  - A late slave response arriving in DONE or IDLE is discarded.
- DONE: one-cycle turnaround with no outputs asserted, → IDLE. This gives the master one cycle to drop or change its request.
- Slave responses outside an owned state are ignored and never forwarded.

## Timing
- Reset: state=IDLE, last_owner=0, counter=0. All outputs are 0: every valid, err, mem_* and rdata.
- Reset mid-transaction: abort immediately, no response is given to either master, and the in-flight slave response is discarded.
- Grant latency: request high in IDLE at edge N → mem_*valid high in cycle N+1.
- Response latency: master sees its response in the same cycle as mem_rvalid/bvalid.
- Minimum transaction: 3 cycles (IDLE, owned state with immediate response, DONE).
- Back-to-back: the next grant is sampled in IDLE. Minimum request-to-request spacing with continuous requests is 3 cycles.
- A request dropped before grant is simply not granted. Masters must not drop a request after grant; behaviour in that case is undefined.
- The timeout error strobe appears in the cycle where counter == TIMEOUT, i.e. TIMEOUT+1 owned cycles after grant.

## Test plan
- IFU only:
  - Stimulus: ifu_araddr=0x80000000; slave answers 2 cycles after mem_arvalid with 0x00000413.
  - Required: ifu_rvalid one cycle with rdata 0x00000413, lsu_rvalid stays 0, state returns to IDLE after DONE.
- Conflict:
  - Stimulus: after reset, IFU read and LSU read both requested in the same cycle.
  - Required: LSU granted first (mem_araddr=lsu addr); IFU granted next; then, with both still requesting, LSU again (alternation).
- LSU write:
  - Stimulus: awaddr=0x80001000, wdata=0xDEADBEEF, wstrb=0xF.
  - Required: mem_awvalid with exactly these values held until mem_bvalid, lsu_bvalid pulses once, lsu_err=0.
- Timeout:
  - Stimulus: TIMEOUT=4, slave never responds to an IFU read.
  - Required: ifu_rvalid=1, ifu_rerr=1, rdata=0 exactly 5 owned cycles after grant; a later mem_rvalid is not forwarded.
- Reset mid-operation:
  - Stimulus: assert rst while in LSU_RD, with mem_rvalid arriving the same cycle.
  - Required: no lsu_rvalid; all outputs 0 the next cycle; state IDLE.
- Stray response:
  - Stimulus: mem_rvalid pulsed in IDLE.
  - Required: neither ifu_rvalid nor lsu_rvalid asserts.
